// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: opcode/funct7 constants and the decoded bundle
// that both the decode stage and the execution unit consume.
package riscv_pkg;

  localparam int DEC_XLEN = 32;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [19:0]         imm;
    logic [4:0]          rs1_idx;
    logic [4:0]          rs2_idx;
    logic [4:0]          rd_idx;
    logic [DEC_XLEN-1:0] pc;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/riscv_insn_fields.sv
// Combinational slicing of one RV32I word into a dec_bundle_t, including
// format-dependent immediate and illegal-encoding detection.
module riscv_insn_fields
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     insn,
  input  logic [XLEN-1:0] insn_pc,
  output dec_bundle_t     bundle
);

  logic        ill;
  logic [19:0] imm_raw;

  always_comb begin
    ill     = (insn[1:0] != 2'b11);
    imm_raw = '0;
    case (insn[6:0])
      OPC_LUI, OPC_AUIPC:            imm_raw = insn[31:12];
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_raw = {{8{insn[31]}}, insn[31:20]};
      OPC_STORE:                     imm_raw = {{8{insn[31]}}, insn[31:25], insn[11:7]};
      OPC_OP: begin
        if (insn[31:25] != F7_BASE && insn[31:25] != F7_ALT)
          ill = 1'b1;
        else if (insn[31:25] == F7_ALT && insn[14:12] != 3'b000 && insn[14:12] != 3'b101)
          ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
  end

  // Illegal words keep their raw fields but never carry an immediate.
  always_comb begin
    bundle         = '0;
    bundle.opcode  = insn[6:0];
    bundle.funct3  = insn[14:12];
    bundle.funct7  = insn[31:25];
    bundle.imm     = ill ? 20'd0 : imm_raw;
    bundle.rs1_idx = insn[19:15];
    bundle.rs2_idx = insn[24:20];
    bundle.rd_idx  = insn[11:7];
    bundle.pc      = DEC_XLEN'(insn_pc);
    bundle.illegal = ill;
  end

endmodule

// File: rtl/riscv_insn_decode.sv
// Decode stage: decodes at push time and buffers bundles in a small FIFO so
// fetch and execute are decoupled with no combinational ready path.
module riscv_insn_decode
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            insn_valid,
  output logic            insn_ready,
  input  logic [31:0]     insn,
  input  logic [XLEN-1:0] insn_pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [19:0]     imm,
  output logic [4:0]      rs1_idx,
  output logic [4:0]      rs2_idx,
  output logic [4:0]      rd_idx,
  output logic [XLEN-1:0] pc,
  output logic            illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  dec_bundle_t   wr_bundle, head;
  dec_bundle_t   mem_q [DEPTH];
  dec_bundle_t   mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  riscv_insn_fields #(.XLEN(XLEN)) u_fields (
    .insn    (insn),
    .insn_pc (insn_pc),
    .bundle  (wr_bundle)
  );

  // Ready depends on registered occupancy only, so a full buffer never
  // accepts even when the head is consumed in the same cycle.
  assign insn_ready = (count_q < CW'(DEPTH));
  assign dec_valid  = (count_q != '0);
  assign push       = insn_valid && insn_ready;
  assign pop        = dec_valid && dec_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_bundle;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head    = dec_valid ? mem_q[rd_ptr_q] : '0;
  assign opcode  = head.opcode;
  assign funct3  = head.funct3;
  assign funct7  = head.funct7;
  assign imm     = head.imm;
  assign rs1_idx = head.rs1_idx;
  assign rs2_idx = head.rs2_idx;
  assign rd_idx  = head.rd_idx;
  assign pc      = XLEN'(head.pc);
  assign illegal = head.illegal;

endmodule

// File: tb/tb_riscv_insn_decode.sv
// Scoreboard bench for riscv_insn_decode: expected bundles are queued on
// accept and compared field by field when the head is consumed.
module tb_riscv_insn_decode;

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic        insn_valid = 1'b0, dec_ready = 1'b0;
  logic [31:0] insn = '0, insn_pc = '0;
  logic        insn_ready, dec_valid, illegal;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [19:0] imm;
  logic [4:0]  rs1_idx, rs2_idx, rd_idx;
  logic [31:0] pc;

  riscv_insn_decode #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .imm(imm),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx), .pc(pc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [19:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        ill;
  } exp_t;
  typedef struct packed {exp_t e; logic [31:0] pc;} sb_t;

  sb_t         sbq[$];
  sb_t         s_mon;
  exp_t        tbl_exp [12];
  logic [31:0] tbl_insn [12];
  int          n_chk = 0, n_pass = 0, cur = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hold_pc;
  logic [6:0]  hold_op;
  logic [19:0] hold_imm;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic exp_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic [19:0] im,
                              logic [4:0] r1, logic [4:0] r2, logic [4:0] rd, logic il);
    exp_t e;
    e.op = op; e.f3 = f3; e.f7 = f7; e.imm = im;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ill = il;
    return e;
  endfunction

  // Looks at the handshakes that the coming rising edge will perform.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (flush) sbq.delete();
      else begin
        if (dec_valid && dec_ready) begin
          if (sbq.size() == 0) chk("unexpected_pop", 1, 0);
          else begin
            s_mon = sbq.pop_front();
            chk("opcode", opcode, s_mon.e.op);
            chk("funct3", funct3, s_mon.e.f3);
            chk("funct7", funct7, s_mon.e.f7);
            chk("imm", imm, s_mon.e.imm);
            chk("rs1", rs1_idx, s_mon.e.rs1);
            chk("rs2", rs2_idx, s_mon.e.rs2);
            chk("rd", rd_idx, s_mon.e.rd);
            chk("pc", pc, s_mon.pc);
            chk("illegal", illegal, s_mon.e.ill);
          end
        end
        if (insn_valid && insn_ready) sbq.push_back(sb_t'({tbl_exp[cur], insn_pc}));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [31:0] p);
    cur = idx; insn = tbl_insn[idx]; insn_pc = p; insn_valid = 1'b1;
  endtask

  initial begin
    tbl_insn[0]  = 32'h002081B3; tbl_exp[0]  = mk(7'h33, 3'd0, 7'h00, 20'h00000, 5'd1, 5'd2,  5'd3,  1'b0); // add
    tbl_insn[1]  = 32'h123452B7; tbl_exp[1]  = mk(7'h37, 3'd5, 7'h09, 20'h12345, 5'd8, 5'd3,  5'd5,  1'b0); // lui
    tbl_insn[2]  = 32'hFFF00093; tbl_exp[2]  = mk(7'h13, 3'd0, 7'h7F, 20'hFFFFF, 5'd0, 5'd31, 5'd1,  1'b0); // addi -1
    tbl_insn[3]  = 32'h0020A423; tbl_exp[3]  = mk(7'h23, 3'd2, 7'h00, 20'h00008, 5'd1, 5'd2,  5'd8,  1'b0); // sw +8
    tbl_insn[4]  = 32'h00000000; tbl_exp[4]  = mk(7'h00, 3'd0, 7'h00, 20'h00000, 5'd0, 5'd0,  5'd0,  1'b1); // zero word
    tbl_insn[5]  = 32'h402081B3; tbl_exp[5]  = mk(7'h33, 3'd0, 7'h20, 20'h00000, 5'd1, 5'd2,  5'd3,  1'b0); // sub
    tbl_insn[6]  = 32'h800000E7; tbl_exp[6]  = mk(7'h67, 3'd0, 7'h40, 20'hFF800, 5'd0, 5'd0,  5'd1,  1'b0); // jalr -2048
    tbl_insn[7]  = 32'hFE112E23; tbl_exp[7]  = mk(7'h23, 3'd2, 7'h7F, 20'hFFFFC, 5'd2, 5'd1,  5'd28, 1'b0); // sw -4
    tbl_insn[8]  = 32'h402091B3; tbl_exp[8]  = mk(7'h33, 3'd1, 7'h20, 20'h00000, 5'd1, 5'd2,  5'd3,  1'b1); // alt f7, f3=1
    tbl_insn[9]  = 32'h002081B1; tbl_exp[9]  = mk(7'h31, 3'd0, 7'h00, 20'h00000, 5'd1, 5'd2,  5'd3,  1'b1); // bits[1:0]!=11
    tbl_insn[10] = 32'h022081B3; tbl_exp[10] = mk(7'h33, 3'd0, 7'h01, 20'h00000, 5'd1, 5'd2,  5'd3,  1'b1); // f7=1
    tbl_insn[11] = 32'h00001517; tbl_exp[11] = mk(7'h17, 3'd1, 7'h00, 20'h00001, 5'd0, 5'd0,  5'd10, 1'b0); // auipc

    // reset state
    #12;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_insn_ready", insn_ready, 1);
    chk("rst_opcode", opcode, 0);
    chk("rst_imm", imm, 0);
    chk("rst_pc", pc, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1; mon_en = 1'b1;
    step();

    // first word latency, then streaming through every table entry
    dec_ready = 1'b1;
    drive(0, 32'h100); step(); insn_valid = 1'b0;
    chk("lat_valid", dec_valid, 1);
    chk("lat_pc", pc, 32'h100);
    step();
    for (int i = 1; i < 12; i++) begin
      drive(i, 32'h100 + 32'(4 * i)); step();
    end
    insn_valid = 1'b0; step(); step();

    // backpressure: two accepts then stall, head held stable
    dec_ready = 1'b0;
    drive(1, 32'h200); step();
    drive(4, 32'h204); step();
    drive(3, 32'h208); step();
    chk("full_ready", insn_ready, 0);
    chk("full_valid", dec_valid, 1);
    hold_pc = pc; hold_op = opcode; hold_imm = imm;
    chk("hold_head_pc", pc, 32'h200);
    step(); step();
    chk("hold_pc", pc, hold_pc);
    chk("hold_op", opcode, hold_op);
    chk("hold_imm", imm, hold_imm);
    chk("hold_ready", insn_ready, 0);
    dec_ready = 1'b1; step();
    chk("after_pop_ready", insn_ready, 1);
    step(); insn_valid = 1'b0; step(); step();

    // simultaneous push and pop with one entry buffered
    dec_ready = 1'b0;
    drive(2, 32'h300); step();
    drive(5, 32'h304); dec_ready = 1'b1; step();
    insn_valid = 1'b0; dec_ready = 1'b0;
    chk("pp_valid", dec_valid, 1);
    chk("pp_ready", insn_ready, 1);
    chk("pp_head_pc", pc, 32'h304);
    chk("pp_head_f7", funct7, 7'h20);
    dec_ready = 1'b1; step(); dec_ready = 1'b0;
    chk("pp_drained", dec_valid, 0);

    // flush while full with a word offered, then while half full
    drive(0, 32'h400); step();
    drive(1, 32'h404); step();
    drive(2, 32'h408); flush = 1'b1; step();
    flush = 1'b0; insn_valid = 1'b0;
    chk("flush_valid", dec_valid, 0);
    chk("flush_ready", insn_ready, 1);
    chk("flush_opcode", opcode, 0);
    step();
    chk("flush_dropped", dec_valid, 0);
    drive(0, 32'h410); step();
    drive(3, 32'h414); flush = 1'b1; step();
    flush = 1'b0; insn_valid = 1'b0;
    chk("flush_push_dropped", dec_valid, 0);
    step();

    // asynchronous reset mid-cycle with two entries buffered
    drive(0, 32'h500); step();
    drive(1, 32'h504); step();
    insn_valid = 1'b0;
    chk("pre_rst_valid", dec_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", dec_valid, 0);
    chk("arst_ready", insn_ready, 1);
    chk("arst_pc", pc, 0);
    chk("arst_opcode", opcode, 0);
    sbq.delete();
    #3 rst_n = 1'b1;
    step();
    dec_ready = 1'b1;
    drive(6, 32'h600); step(); insn_valid = 1'b0;
    chk("post_rst_lat_valid", dec_valid, 1);
    chk("post_rst_lat_pc", pc, 32'h600);
    step(); step();

    chk("sb_empty", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/riscv_insn_decode.md
Name: riscv_insn_decode

Overview:
Front-end decode stage feeding the execution unit. Accepts raw 32-bit RV32I instruction words and their PCs over a valid/ready handshake. Slices each word into the opcode/funct3/funct7/imm/register-index bundle the execution unit consumes, and flags illegal encodings. Holds decoded results in a small registered FIFO so upstream fetch and downstream execute are decoupled with no combinational ready path.

Parameters:
XLEN, 32, data/PC width in bits
DEPTH, 2, decoded-entry buffer depth (power of two, >= 2)

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous; discards all buffered entries
insn_valid  input  1  upstream word valid
insn_ready  output  1  block can accept a word this cycle
insn  input  32  raw instruction word
insn_pc  input  XLEN  PC of insn
dec_valid  output  1  head entry valid
dec_ready  input  1  downstream consumes head entry
opcode  output  7  insn[6:0]
funct3  output  3  insn[14:12]
funct7  output  7  insn[31:25]
imm  output  20  decoded immediate, format-dependent
rs1_idx  output  5  insn[19:15]
rs2_idx  output  5  insn[24:20]
rd_idx  output  5  insn[11:7]
pc  output  XLEN  insn_pc of the head entry
illegal  output  1  head entry is an unsupported or malformed encoding

Behaviour:
- Reset (rst_n low, asynchronous): count=0, read/write pointers=0, dec_valid=0, insn_ready=1. All bundle outputs drive 0 while the buffer is empty, including during reset.
- Handshakes: a push occurs when insn_valid && insn_ready; a pop occurs when dec_valid && dec_ready.
- insn_ready = (count < DEPTH). It is a registered-state function only and never depends on dec_ready. At full, no push occurs even if a pop happens in the same cycle.
- Latency: a word accepted at edge N is visible at dec_* after edge N if the buffer was empty, i.e. one cycle.
- Ordering: strict FIFO.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Bundle outputs come from the head entry and are held stable while dec_valid && !dec_ready.
- flush: at the next edge count=0 and pointers=0. Flush wins over a simultaneous push or pop; the pushed word is dropped.
- Decode runs at push time, so the stored entry is already decoded. Immediate by opcode:
  - LUI 0110111 and AUIPC 0010111: imm = insn[31:12].
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: imm = insn[31:20] sign-extended to 20 bits.
  - STORE 0100011: imm = {insn[31:25], insn[11:7]} sign-extended to 20 bits.
  - OP 0110011: imm = 0.
- illegal=1 when any of the following holds:
  - insn[1:0] != 2'b11;
  - the opcode is not one of the seven listed above;
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7=0100000 and funct3 not in {000, 101}.
- An illegal entry is still queued. Its opcode/funct/index fields pass through raw, and imm is 0.
- Reset asserted mid-stream: all buffered entries are lost immediately, with no partial outputs.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode localparams: OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR;
  - funct7 constants F7_BASE and F7_ALT;
  - a packed struct dec_bundle_t {opcode, funct3, funct7, imm, rs1_idx, rs2_idx, rd_idx, pc, illegal}, which the execution unit also imports.
- One sub-module, riscv_insn_fields: purely combinational word-to-dec_bundle_t slicing, immediate and illegal logic.
- The top module owns the FIFO storage, pointers and count.

Test Plan:
- Reset, then push 0x002081B3 (add x3,x1,x2) at pc=0x100 -> next cycle dec_valid=1, opcode=0110011, funct3=0, funct7=0, rs1=1, rs2=2, rd=3, imm=0, illegal=0, pc=0x100.
- Push 0x123452B7 (lui x5,0x12345) -> imm=0x12345, rd=5; then 0xFFF00093 (addi x1,x0,-1) -> imm=0xFFFFF, rd=1.
- Push 0x0020A423 (sw x2,8(x1)) -> imm=0x00008, rs1=1, rs2=2. Push 0x402081B3 (sub) -> funct7=0100000, illegal=0. Push 0x00000000 -> illegal=1, imm=0.
- Hold dec_ready=0 and push three words -> insn_ready drops after 2 accepts, the third is held upstream, outputs stay stable. Raise dec_ready -> order 1,2,3 is preserved and count never exceeds 2.
- With count=1, push and pop in the same cycle -> count stays 1 and the head advances to the new word. With count=2, assert flush together with insn_valid -> next cycle dec_valid=0, insn_ready=1, the pushed word is dropped.
- Drop rst_n asynchronously mid-cycle with 2 entries buffered -> dec_valid=0 and insn_ready=1 immediately. After release, the first push reappears with 1-cycle latency.
